data_mem_store_unit: RTL and testbench

- Store-side counterpart of the load data path; sits between the execute stage and a word-only data memory.
- Accepts one store request (SW/SH/SB) per handshake and places the halfword or byte into the correct lanes.
- Word stores are written directly. Sub-word stores use a read-modify-write sequence, because the memory has no byte enables.
- Lane order is big-endian: byte offset 0 = bits [31:24], halfword offset 0 = bits [31:16]. This matches the load path, so an aligned store/load round-trips.

---
 rtl/data_mem_store_if.sv | 53 +++++
 rtl/data_mem_store_unit.sv | 166 ++++++++++++++++
 tb/tb_data_mem_store_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_store_if.sv
// Store-unit bus: execute-side request handshake plus the word-only data memory port.
// DATA_MEM_STORE_MISALIGN_TRAP_EN adds the misaligned flag to the bundle.
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif
`ifndef FUNCT3_SB
`define FUNCT3_SB 3'b000
`endif
`ifndef FUNCT3_SH
`define FUNCT3_SH 3'b001
`endif
`ifndef FUNCT3_SW
`define FUNCT3_SW 3'b010
`endif

interface data_mem_store_if #(
   parameter int unsigned N = 32
);
   logic                     req_valid;
   logic                     req_ready;
   logic [N-1:0]             req_addr;
   logic [N-1:0]             req_data;
   logic [`FUNCT3_WIDTH-1:0] funct3;
   logic [N-1:0]             mem_addr;
   logic                     mem_rd_en;
   logic [N-1:0]             mem_rdata;
   logic                     mem_rvalid;
   logic                     mem_wr_en;
   logic [N-1:0]             mem_wdata;
   logic                     done;
   logic                     busy;
`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
   logic                     misaligned;

   modport master (
      output req_valid, req_addr, req_data, funct3, mem_rdata, mem_rvalid,
      input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, busy, misaligned
   );
   modport slave (
      input  req_valid, req_addr, req_data, funct3, mem_rdata, mem_rvalid,
      output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, busy, misaligned
   );
`else
   modport master (
      output req_valid, req_addr, req_data, funct3, mem_rdata, mem_rvalid,
      input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, busy
   );
   modport slave (
      input  req_valid, req_addr, req_data, funct3, mem_rdata, mem_rvalid,
      output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, busy
   );
`endif
endinterface

// File: rtl/data_mem_store_unit.sv
// Store unit: SW written directly, SH/SB via read-modify-write into big-endian lanes.
// Optional DATA_MEM_STORE_MISALIGN_TRAP_EN rejects misaligned SW/SH with a misaligned pulse.
module data_mem_store_unit #(
   parameter int unsigned N = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   data_mem_store_if.slave bus
);

   localparam int unsigned F3W = `FUNCT3_WIDTH;
   localparam logic [F3W-1:0] F3_SB = F3W'(`FUNCT3_SB);
   localparam logic [F3W-1:0] F3_SH = F3W'(`FUNCT3_SH);
   localparam logic [F3W-1:0] F3_SW = F3W'(`FUNCT3_SW);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e         state_q, state_d;
   logic [1:0]     offset_q, offset_d;
   logic [15:0]    data_q, data_d;
   logic [F3W-1:0] f3_q, f3_d;
   logic [N-1:0]   mem_addr_q, mem_addr_d;
   logic [N-1:0]   mem_wdata_q, mem_wdata_d;
   logic           mem_rd_en_q, mem_rd_en_d;
   logic           mem_wr_en_q, mem_wr_en_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;
   logic           req_ready_q, req_ready_d;
`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
   logic           misaligned_q, misaligned_d;
`endif

   logic           accept_c;
   logic           trap_c;
   logic [N-1:0]   merged_c;

   assign accept_c = bus.req_valid && req_ready_q;

`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
   assign trap_c = ((bus.funct3 == F3_SW) && (bus.req_addr[1:0] != 2'b00)) ||
                   ((bus.funct3 == F3_SH) && bus.req_addr[0]);
`else
   assign trap_c = 1'b0;
`endif

   // State register plus all registered outputs and request latches.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         offset_q     <= 2'b00;
         data_q       <= '0;
         f3_q         <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_rd_en_q  <= 1'b0;
         mem_wr_en_q  <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         req_ready_q  <= 1'b1;
`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
         misaligned_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         offset_q     <= offset_d;
         data_q       <= data_d;
         f3_q         <= f3_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_rd_en_q  <= mem_rd_en_d;
         mem_wr_en_q  <= mem_wr_en_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         req_ready_q  <= req_ready_d;
`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
         misaligned_q <= misaligned_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               if (trap_c) begin
                  state_d = S_DONE;
               end else begin
                  case (bus.funct3)
                     F3_SW:        state_d = S_WRITE;
                     F3_SH, F3_SB: state_d = S_READ;
                     default:      state_d = S_DONE;
                  endcase
               end
            end
         end
         S_READ:  state_d = S_WAIT;
         S_WAIT:  if (bus.mem_rvalid) state_d = S_WRITE;
         S_WRITE: state_d = S_IDLE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Merge the latched halfword/byte into the word read back; lane 0 is the MSB.
   always_comb begin
      merged_c = bus.mem_rdata;
      if (f3_q == F3_SH) begin
         if (offset_q[1]) merged_c[15:0]  = data_q;
         else             merged_c[31:16] = data_q;
      end else begin
         case (offset_q)
            2'd0:    merged_c[31:24] = data_q[7:0];
            2'd1:    merged_c[23:16] = data_q[7:0];
            2'd2:    merged_c[15:8]  = data_q[7:0];
            default: merged_c[7:0]   = data_q[7:0];
         endcase
      end
   end

   // Output logic: strobes follow the state being entered so they appear as registered Moore outputs.
   always_comb begin
      offset_d    = offset_q;
      data_d      = data_q;
      f3_d        = f3_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      req_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      mem_rd_en_d = (state_d == S_READ);
      mem_wr_en_d = (state_d == S_WRITE);
      done_d      = (state_d == S_WRITE) || (state_d == S_DONE);
`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
      misaligned_d = (state_q == S_IDLE) && accept_c && trap_c;
`endif
      if ((state_q == S_IDLE) && accept_c) begin
         offset_d   = bus.req_addr[1:0];
         data_d     = bus.req_data[15:0];
         f3_d       = bus.funct3;
         mem_addr_d = {bus.req_addr[N-1:2], 2'b00};
         if (bus.funct3 == F3_SW) mem_wdata_d = bus.req_data;
      end
      if ((state_q == S_WAIT) && bus.mem_rvalid) begin
         mem_wdata_d = merged_c;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.busy       = busy_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_rd_en  = mem_rd_en_q;
   assign bus.mem_wr_en  = mem_wr_en_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.done       = done_q;
`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
   assign bus.misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_data_mem_store_unit.sv
// Bench for data_mem_store_unit: directed vector table, hand-written reset sequence,
// and randomized stores checked against a byte-lane reference model.
module tb_data_mem_store_unit;

   localparam logic [2:0] F_SB = 3'b000;
   localparam logic [2:0] F_SH = 3'b001;
   localparam logic [2:0] F_SW = 3'b010;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   data_mem_store_if #(.N(32)) bus ();

   data_mem_store_unit #(.N(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rdata;
      int          dly;
      int          exp_rd;
      int          exp_wr;
      int          exp_mis;
      int          exp_lat;
      logic [31:0] exp_waddr;
      logic [31:0] exp_wdata;
   } vec_t;

   typedef struct {
      int          rd_cnt;
      int          wr_cnt;
      int          done_cnt;
      int          done_cyc;
      int          busy_low;
      int          ready_hi;
      int          mis;
      int          ready_after;
      int          busy_after;
      int          extra_after;
      logic [31:0] rd_addr;
      logic [31:0] wr_addr;
      logic [31:0] wr_data;
   } res_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Reference: view the word as four big-endian bytes and overwrite the addressed ones.
   function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] data, input logic [31:0] old);
      logic [7:0]  b [4];
      logic [31:0] w;
      int          off;
      off = int'(addr[1:0]);
      for (int k = 0; k < 4; k++) b[k] = old[31-8*k -: 8];
      if (f3 == F_SB) begin
         b[off] = data[7:0];
      end else if (f3 == F_SH) begin
         off = (off / 2) * 2;
         b[off]   = data[15:8];
         b[off+1] = data[7:0];
      end else begin
         for (int k = 0; k < 4; k++) b[k] = data[31-8*k -: 8];
      end
      w = '0;
      for (int k = 0; k < 4; k++) w[31-8*k -: 8] = b[k];
      return w;
   endfunction

   function automatic int is_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
      if (f3 == F_SW && addr[1:0] != 2'b00) return 1;
      if (f3 == F_SH && addr[0]) return 1;
`else
      if (f3 == 3'b111 && addr == 32'hFFFF_FFFF) return 0;
`endif
      return 0;
   endfunction

   task automatic add_vec(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int dly, input int exp_rd, input int exp_wr,
                          input int exp_mis, input int exp_lat, input logic [31:0] exp_waddr,
                          input logic [31:0] exp_wdata);
      vec_t v;
      v.f3 = f3; v.addr = addr; v.data = data; v.rdata = rdata; v.dly = dly;
      v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_mis = exp_mis; v.exp_lat = exp_lat;
      v.exp_waddr = exp_waddr; v.exp_wdata = exp_wdata;
      vecs.push_back(v);
   endtask

   // Drive one request, act as the memory, and record what the unit did until its done pulse.
   task automatic run_txn(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int dly, output res_t r);
      int rd_cyc;
      r.rd_cnt = 0; r.wr_cnt = 0; r.done_cnt = 0; r.done_cyc = 0; r.busy_low = 0;
      r.ready_hi = 0; r.mis = 0; r.ready_after = 0; r.busy_after = 0; r.extra_after = 0;
      r.rd_addr = '0; r.wr_addr = '0; r.wr_data = '0;
      bus.req_valid  = 1'b1;
      bus.funct3     = f3;
      bus.req_addr   = addr;
      bus.req_data   = data;
      bus.mem_rvalid = 1'b0;
      @(posedge clk); #1;
      rd_cyc = -1;
      for (int c = 1; c <= 40 && r.done_cnt == 0; c++) begin
         if (bus.mem_rd_en) begin r.rd_cnt++; r.rd_addr = bus.mem_addr; rd_cyc = c; end
         if (bus.mem_wr_en) begin r.wr_cnt++; r.wr_addr = bus.mem_addr; r.wr_data = bus.mem_wdata; end
         if (bus.done) begin r.done_cnt++; r.done_cyc = c; end
         if (!bus.busy) r.busy_low++;
         if (bus.req_ready) r.ready_hi++;
`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
         if (bus.misaligned) r.mis++;
`endif
         bus.req_valid = 1'($urandom);
         bus.req_addr  = $urandom;
         bus.req_data  = $urandom;
         bus.funct3    = 3'($urandom);
         if (rd_cyc == c) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = ~rdata;
         end else if (rd_cyc > 0 && c == rd_cyc + dly) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
         end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
         end
         @(posedge clk); #1;
      end
      r.ready_after = bus.req_ready ? 1 : 0;
      r.busy_after  = bus.busy ? 1 : 0;
      r.extra_after = (bus.mem_wr_en || bus.mem_rd_en || bus.done) ? 1 : 0;
      bus.req_valid  = 1'b0;
      bus.mem_rvalid = 1'b0;
   endtask

   task automatic apply(input string tag, input vec_t v);
      res_t r;
      run_txn(v.f3, v.addr, v.data, v.rdata, v.dly, r);
      chk({tag, " done_count"}, 32'(r.done_cnt), 32'd1);
      chk({tag, " latency"}, 32'(r.done_cyc), 32'(v.exp_lat));
      chk({tag, " rd_count"}, 32'(r.rd_cnt), 32'(v.exp_rd));
      chk({tag, " wr_count"}, 32'(r.wr_cnt), 32'(v.exp_wr));
      if (v.exp_rd != 0) chk({tag, " rd_addr"}, r.rd_addr, v.exp_waddr);
      if (v.exp_wr != 0) begin
         chk({tag, " wr_addr"}, r.wr_addr, v.exp_waddr);
         chk({tag, " wr_data"}, r.wr_data, v.exp_wdata);
      end
      chk({tag, " busy_low"}, 32'(r.busy_low), 32'd0);
      chk({tag, " ready_while_busy"}, 32'(r.ready_hi), 32'd0);
      chk({tag, " ready_after"}, 32'(r.ready_after), 32'd1);
      chk({tag, " busy_after"}, 32'(r.busy_after), 32'd0);
      chk({tag, " strobes_after"}, 32'(r.extra_after), 32'd0);
`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
      chk({tag, " misaligned"}, 32'(r.mis), 32'(v.exp_mis));
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   stray;
      int   rst_hits;
      n_chk  = 0;
      n_pass = 0;
      clk    = 1'b0;
      rst_n  = 1'b0;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.funct3 = '0;
      bus.mem_rdata = '0;   bus.mem_rvalid = 1'b0;

      // Directed table: f3, addr, data, rdata, dly, rd, wr, mis, latency, word addr, write data.
      add_vec(F_SW, 32'h100, 32'hDEADBEEF, 32'h0,        1, 0, 1, 0, 1, 32'h100, 32'hDEADBEEF);
      add_vec(F_SB, 32'h203, 32'h000000AB, 32'h11223344, 1, 1, 1, 0, 3, 32'h200, 32'h112233AB);
      add_vec(F_SH, 32'h300, 32'hFFFFCAFE, 32'h11223344, 4, 1, 1, 0, 6, 32'h300, 32'hCAFE3344);
      add_vec(3'b111, 32'h500, 32'h12345678, 32'h0,      1, 0, 0, 0, 1, 32'h500, 32'h0);
      add_vec(3'b100, 32'h504, 32'h12345678, 32'h0,      1, 0, 0, 0, 1, 32'h504, 32'h0);
      add_vec(F_SB, 32'h200, 32'h12345678, 32'hAABBCCDD, 2, 1, 1, 0, 4, 32'h200, 32'h78BBCCDD);
      add_vec(F_SB, 32'h201, 32'h000000FF, 32'h00000000, 1, 1, 1, 0, 3, 32'h200, 32'h00FF0000);
      add_vec(F_SB, 32'h202, 32'h0000005A, 32'hFFFFFFFF, 3, 1, 1, 0, 5, 32'h200, 32'hFFFF5AFF);
      add_vec(F_SH, 32'h302, 32'h0000BEEF, 32'h11223344, 1, 1, 1, 0, 3, 32'h300, 32'h1122BEEF);
`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
      add_vec(F_SW, 32'h102, 32'hCAFEF00D, 32'h0,        1, 0, 0, 1, 1, 32'h100, 32'h0);
      add_vec(F_SH, 32'h303, 32'h00001234, 32'hAABBCCDD, 2, 0, 0, 1, 1, 32'h300, 32'h0);
`else
      add_vec(F_SW, 32'h102, 32'hCAFEF00D, 32'h0,        1, 0, 1, 0, 1, 32'h100, 32'hCAFEF00D);
      add_vec(F_SH, 32'h303, 32'h00001234, 32'hAABBCCDD, 2, 1, 1, 0, 4, 32'h300, 32'hAABB1234);
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("rst req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst strobes", {29'd0, bus.mem_rd_en, bus.mem_wr_en, bus.done}, 32'd0);
      chk("rst mem_addr", bus.mem_addr, 32'h0);
      chk("rst mem_wdata", bus.mem_wdata, 32'h0);
`ifdef DATA_MEM_STORE_MISALIGN_TRAP_EN
      chk("rst misaligned", 32'(bus.misaligned), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

      // Reset while waiting for read data: the late rvalid must not produce a write or done.
      bus.req_valid = 1'b1; bus.funct3 = F_SB; bus.req_addr = 32'h401; bus.req_data = 32'h77;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("midrst rd_en", 32'(bus.mem_rd_en), 32'd1);
      @(posedge clk); #1;
      chk("midrst waiting", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h55667788;
      chk("midrst req_ready", 32'(bus.req_ready), 32'd1);
      chk("midrst busy", 32'(bus.busy), 32'd0);
      rst_hits = 0;
      repeat (5) begin
         if (bus.mem_wr_en || bus.done || bus.mem_rd_en) rst_hits++;
         @(posedge clk); #1;
      end
      bus.mem_rvalid = 1'b0;
      chk("midrst no_write", 32'(rst_hits), 32'd0);

      // Randomized stores with idle gaps carrying stray rvalid pulses.
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         int sel;
         int trap;
         int legal;
         sel = int'($urandom_range(0, 9));
         if (sel < 3)      v.f3 = F_SB;
         else if (sel < 6) v.f3 = F_SH;
         else if (sel < 9) v.f3 = F_SW;
         else              v.f3 = 3'(3 + $urandom_range(0, 4));
         v.addr  = $urandom;
         v.data  = $urandom;
         v.rdata = $urandom;
         v.dly   = int'($urandom_range(1, 4));
         legal   = (v.f3 == F_SB || v.f3 == F_SH || v.f3 == F_SW) ? 1 : 0;
         trap    = legal ? is_trap(v.f3, v.addr) : 0;
         v.exp_mis   = trap;
         v.exp_wr    = (legal != 0 && trap == 0) ? 1 : 0;
         v.exp_rd    = (v.exp_wr != 0 && v.f3 != F_SW) ? 1 : 0;
         v.exp_lat   = (v.exp_rd != 0) ? v.dly + 2 : 1;
         v.exp_waddr = v.addr & 32'hFFFF_FFFC;
         v.exp_wdata = ref_store(v.f3, v.addr, v.data, v.rdata);
         apply($sformatf("rnd%0d", i), v);
         repeat (int'($urandom_range(0, 2))) begin
            bus.mem_rvalid = 1'($urandom);
            bus.mem_rdata  = $urandom;
            @(posedge clk); #1;
            if (bus.mem_wr_en || bus.mem_rd_en || bus.done || bus.busy) stray++;
         end
         bus.mem_rvalid = 1'b0;
      end
      chk("idle stray activity", 32'(stray), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
